// File: rtl/imem_dmem_arbiter_pkg.sv
// Shared types for the fetch/load-store memory arbiter: owner tags, FSM states
// and the selected memory request bundle.
package riscv_structures;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_IF,
        OWN_D
    } arb_owner_e;

    typedef enum logic {
        ARB_IDLE,
        ARB_WAIT
    } arb_state_e;

    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_req_t;

    localparam logic [3:0] STARVE_SAT = 4'd15;

endpackage

// File: rtl/imem_dmem_arbiter_if.sv
// Bus bundle between the core (fetch + load/store), the arbiter and the memory array.
interface imem_dmem_arbiter_if #(
    parameter int AW = 8
);
    // Handshake: a requester raises *_req with stable address/data and holds it until
    // *_gnt is seen high in the same cycle; dropping *_req before that is legal.
    // *_rvalid is a one-cycle response pulse with no back-pressure.
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;

    logic        d_req;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;

    logic          mem_en;
    logic          mem_we;
    logic [3:0]    mem_be;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    modport master (
        output if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_en, mem_we, mem_be, mem_addr, mem_wdata
    );

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_en, mem_we, mem_be, mem_addr, mem_wdata
    );

endinterface

// File: rtl/imem_dmem_arb_pick.sv
// Winner select: data has priority unless fetch has been denied STARVE_LIMIT times in a row.
module imem_dmem_arb_pick
    import riscv_structures::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic       if_req_i,
    input  logic       d_req_i,
    input  logic [3:0] starve_cnt_i,
    output arb_owner_e winner_o
);

    logic fetch_starved;

    assign fetch_starved = if_req_i && (starve_cnt_i >= 4'(STARVE_LIMIT));

    always_comb begin
        winner_o = OWN_NONE;
        if (d_req_i && !fetch_starved) begin
            winner_o = OWN_D;
        end else if (if_req_i) begin
            winner_o = OWN_IF;
        end
    end

endmodule

// File: rtl/imem_dmem_arbiter.sv
// Single-port memory arbiter: one access in flight, fixed-latency response routed
// back to the requester that owned the access.
module imem_dmem_arbiter
    import riscv_structures::*;
#(
    parameter int AW           = 8,
    parameter int MEM_LATENCY  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst,
    imem_dmem_arbiter_if.slave  bus,
    output arb_state_e          state_o
);

    arb_state_e state_q, state_d;
    arb_owner_e owner_q, owner_d;
    arb_owner_e winner;
    logic [2:0] lat_cnt_q, lat_cnt_d;
    logic [3:0] starve_cnt_q, starve_cnt_d;
    logic       store_q, store_d;
    logic       grant_ok;
    logic       resp;
    mem_req_t   sel;
    logic       unused_addr_bits;

    imem_dmem_arb_pick #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_pick (
        .if_req_i    (bus.if_req),
        .d_req_i     (bus.d_req),
        .starve_cnt_i(starve_cnt_q),
        .winner_o    (winner)
    );

    // The response cycle doubles as an issue slot, giving back-to-back accesses.
    assign grant_ok = !rst && ((state_q == ARB_IDLE) || (lat_cnt_q == 3'd0));
    assign resp     = !rst && (state_q == ARB_WAIT) && (lat_cnt_q == 3'd0);

    always_comb begin
        if (winner == OWN_D) begin
            sel = '{we: bus.d_we, be: bus.d_be, addr: bus.d_addr, wdata: bus.d_wdata};
        end else begin
            sel = '{we: 1'b0, be: 4'hF, addr: bus.if_addr, wdata: 32'h0};
        end
    end

    assign bus.if_gnt    = grant_ok && (winner == OWN_IF);
    assign bus.d_gnt     = grant_ok && (winner == OWN_D);
    assign bus.mem_en    = grant_ok && (winner != OWN_NONE);
    assign bus.mem_we    = sel.we;
    assign bus.mem_be    = sel.be;
    assign bus.mem_addr  = sel.addr[AW+1:2];
    assign bus.mem_wdata = sel.wdata;

    assign unused_addr_bits = ^{sel.addr[31:AW+2], sel.addr[1:0]};

    assign bus.if_rvalid = resp && (owner_q == OWN_IF);
    assign bus.d_rvalid  = resp && (owner_q == OWN_D);
    assign bus.if_rdata  = bus.if_rvalid ? bus.mem_rdata : 32'h0;
    assign bus.d_rdata   = (bus.d_rvalid && !store_q) ? bus.mem_rdata : 32'h0;

    assign state_o = state_q;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        lat_cnt_d    = lat_cnt_q;
        store_d      = store_q;
        starve_cnt_d = starve_cnt_q;

        if ((state_q == ARB_WAIT) && (lat_cnt_q != 3'd0)) begin
            lat_cnt_d = lat_cnt_q - 3'd1;
        end

        if (grant_ok) begin
            if (winner != OWN_NONE) begin
                state_d   = ARB_WAIT;
                owner_d   = winner;
                lat_cnt_d = 3'(MEM_LATENCY - 1);
                store_d   = (winner == OWN_D) && bus.d_we;
            end else begin
                state_d = ARB_IDLE;
                owner_d = OWN_NONE;
            end

            if (bus.if_gnt) begin
                starve_cnt_d = 4'd0;
            end else if (bus.if_req && (starve_cnt_q != STARVE_SAT)) begin
                starve_cnt_d = starve_cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ARB_IDLE;
            owner_q      <= OWN_NONE;
            lat_cnt_q    <= 3'd0;
            store_q      <= 1'b0;
            starve_cnt_q <= 4'd0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            lat_cnt_q    <= lat_cnt_d;
            store_q      <= store_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Bench for the memory arbiter: two instances (latency 1 and 3), each with a simple
// memory model; directed scenarios plus a randomized run against a cycle-level model.
module tb_imem_dmem_arbiter;
    import riscv_structures::*;

    localparam int AW = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    imem_dmem_arbiter_if #(.AW(AW)) bus_a ();
    imem_dmem_arbiter_if #(.AW(AW)) bus_b ();
    arb_state_e state_a, state_b;

    imem_dmem_arbiter #(.AW(AW), .MEM_LATENCY(1), .STARVE_LIMIT(4)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a.slave), .state_o(state_a)
    );
    imem_dmem_arbiter #(.AW(AW), .MEM_LATENCY(3), .STARVE_LIMIT(4)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b.slave), .state_o(state_b)
    );

    int n_checks = 0;
    int n_errors = 0;

    function automatic logic [31:0] init_word(int i);
        return (i == 0) ? 32'h0000_0513 : (32'h1357_0000 | 32'(i * 7));
    endfunction

    // Memory models: latency-1 array for A, three-stage read pipeline for B.
    logic [31:0] mem_a [256];
    logic [31:0] mem_b [256];
    logic [31:0] rd_a;
    logic [31:0] rd_b [3];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem_a[i] <= init_word(i);
            rd_a <= 32'hDEAD_BEEF;
        end else begin
            rd_a <= bus_a.mem_en ? mem_a[bus_a.mem_addr] : 32'hDEAD_BEEF;
            if (bus_a.mem_en && bus_a.mem_we)
                for (int b = 0; b < 4; b++)
                    if (bus_a.mem_be[b]) mem_a[bus_a.mem_addr][8*b +: 8] <= bus_a.mem_wdata[8*b +: 8];
        end
    end
    assign bus_a.mem_rdata = rd_a;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem_b[i] <= init_word(i);
            for (int s = 0; s < 3; s++) rd_b[s] <= 32'hDEAD_BEEF;
        end else begin
            rd_b[0] <= bus_b.mem_en ? mem_b[bus_b.mem_addr] : 32'hDEAD_BEEF;
            rd_b[1] <= rd_b[0];
            rd_b[2] <= rd_b[1];
            if (bus_b.mem_en && bus_b.mem_we)
                for (int b = 0; b < 4; b++)
                    if (bus_b.mem_be[b]) mem_b[bus_b.mem_addr][8*b +: 8] <= bus_b.mem_wdata[8*b +: 8];
        end
    end
    assign bus_b.mem_rdata = rd_b[2];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus_a.if_req = 1'b0; bus_a.if_addr = 32'h0;
        bus_a.d_req = 1'b0; bus_a.d_we = 1'b0; bus_a.d_be = 4'h0;
        bus_a.d_addr = 32'h0; bus_a.d_wdata = 32'h0;
        bus_b.if_req = 1'b0; bus_b.if_addr = 32'h0;
        bus_b.d_req = 1'b0; bus_b.d_we = 1'b0; bus_b.d_be = 4'h0;
        bus_b.d_addr = 32'h0; bus_b.d_wdata = 32'h0;
    endtask

    function automatic logic [31:0] rand_addr();
        return ($urandom & 32'hFFFF_FC00) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
    endfunction

    // Randomized-run model state and scoreboard.
    logic [31:0] ref_mem [256];
    logic [31:0] exp_q[$];
    int          due_q[$];
    bit          tgt_q[$];

    initial begin
        bit          if_pend, d_pend, allowed, exp_i, exp_d;
        bit          exp_iv, exp_dv;
        logic [31:0] exp_id, exp_dd;
        logic [31:0] i_addr, d_addr, d_wdata, g_addr;
        logic [3:0]  d_be;
        bit          d_we;
        int          busy_until, starve, widx;
        bit          cont_d [6];

        idle_inputs();
        rst = 1'b1;
        bus_a.if_req = 1'b1;
        bus_a.d_req  = 1'b1;
        next_cycle();
        @(negedge clk);
        check_eq("rst_if_gnt", 32'(bus_a.if_gnt), 32'd0);
        check_eq("rst_d_gnt", 32'(bus_a.d_gnt), 32'd0);
        check_eq("rst_mem_en", 32'(bus_a.mem_en), 32'd0);
        check_eq("rst_if_rvalid", 32'(bus_a.if_rvalid), 32'd0);
        check_eq("rst_d_rvalid", 32'(bus_a.d_rvalid), 32'd0);
        check_eq("rst_if_rdata", bus_a.if_rdata, 32'h0);
        check_eq("rst_d_rdata", bus_a.d_rdata, 32'h0);
        check_eq("rst_state_a", 32'(state_a), 32'(ARB_IDLE));
        check_eq("rst_state_b", 32'(state_b), 32'(ARB_IDLE));
        bus_a.if_req = 1'b0;
        bus_a.d_req  = 1'b0;
        next_cycle();
        rst = 1'b0;

        // Single fetch at word 0.
        bus_a.if_req = 1'b1; bus_a.if_addr = 32'h0;
        @(negedge clk);
        check_eq("fetch_if_gnt", 32'(bus_a.if_gnt), 32'd1);
        check_eq("fetch_d_gnt", 32'(bus_a.d_gnt), 32'd0);
        check_eq("fetch_mem_addr", 32'(bus_a.mem_addr), 32'd0);
        check_eq("fetch_mem_we", 32'(bus_a.mem_we), 32'd0);
        check_eq("fetch_mem_be", 32'(bus_a.mem_be), 32'hF);
        next_cycle();
        bus_a.if_req = 1'b0;
        @(negedge clk);
        check_eq("fetch_if_rvalid", 32'(bus_a.if_rvalid), 32'd1);
        check_eq("fetch_if_rdata", bus_a.if_rdata, 32'h0000_0513);
        check_eq("fetch_d_rvalid", 32'(bus_a.d_rvalid), 32'd0);
        next_cycle();
        @(negedge clk);
        check_eq("fetch_pulse_end", 32'(bus_a.if_rvalid), 32'd0);
        next_cycle();

        // Store 123 at 0x78, then back-to-back load of the same address.
        bus_a.d_req = 1'b1; bus_a.d_we = 1'b1; bus_a.d_be = 4'hF;
        bus_a.d_addr = 32'h78; bus_a.d_wdata = 32'd123;
        @(negedge clk);
        check_eq("st_d_gnt", 32'(bus_a.d_gnt), 32'd1);
        check_eq("st_mem_addr", 32'(bus_a.mem_addr), 32'd30);
        check_eq("st_mem_we", 32'(bus_a.mem_we), 32'd1);
        check_eq("st_mem_wdata", bus_a.mem_wdata, 32'd123);
        next_cycle();
        bus_a.d_we = 1'b0; bus_a.d_wdata = 32'h0;
        @(negedge clk);
        check_eq("st_ack_rvalid", 32'(bus_a.d_rvalid), 32'd1);
        check_eq("st_ack_rdata", bus_a.d_rdata, 32'h0);
        check_eq("ld_d_gnt", 32'(bus_a.d_gnt), 32'd1);
        check_eq("ld_mem_addr", 32'(bus_a.mem_addr), 32'd30);
        check_eq("ld_mem_we", 32'(bus_a.mem_we), 32'd0);
        next_cycle();
        bus_a.d_req = 1'b0;
        @(negedge clk);
        check_eq("ld_rvalid", 32'(bus_a.d_rvalid), 32'd1);
        check_eq("ld_rdata", bus_a.d_rdata, 32'd123);
        check_eq("ld_if_rvalid", 32'(bus_a.if_rvalid), 32'd0);
        next_cycle();

        // Address wrap: 0x400 maps to word 0.
        bus_a.if_req = 1'b1; bus_a.if_addr = 32'h400;
        @(negedge clk);
        check_eq("wrap_mem_addr", 32'(bus_a.mem_addr), 32'd0);
        next_cycle();
        bus_a.if_req = 1'b0;
        @(negedge clk);
        check_eq("wrap_rdata", bus_a.if_rdata, init_word(0));
        next_cycle();

        // Contention: both held high; data four times, fetch once, then data again.
        cont_d = '{1, 1, 1, 1, 0, 1};
        bus_a.d_req = 1'b1; bus_a.d_addr = 32'h10;
        bus_a.if_req = 1'b1; bus_a.if_addr = 32'h0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check_eq("cont_d_gnt", 32'(bus_a.d_gnt), 32'(cont_d[k]));
            check_eq("cont_if_gnt", 32'(bus_a.if_gnt), 32'(!cont_d[k]));
            next_cycle();
        end
        bus_a.d_req = 1'b0; bus_a.if_req = 1'b0;
        next_cycle();

        // Latency 3: back-to-back fetches at 0x0 and 0x4.
        for (int k = 0; k < 8; k++) begin
            bus_b.if_req  = (k <= 3);
            bus_b.if_addr = (k == 0) ? 32'h0 : 32'h4;
            @(negedge clk);
            check_eq("l3_if_gnt", 32'(bus_b.if_gnt), 32'((k == 0) || (k == 3)));
            check_eq("l3_if_rvalid", 32'(bus_b.if_rvalid), 32'((k == 3) || (k == 6)));
            check_eq("l3_if_rdata", bus_b.if_rdata,
                     (k == 3) ? init_word(0) : ((k == 6) ? init_word(1) : 32'h0));
            check_eq("l3_d_rvalid", 32'(bus_b.d_rvalid), 32'd0);
            next_cycle();
        end

        // Latency 3: reset one cycle after a grant drops the in-flight response.
        for (int k = 0; k < 6; k++) begin
            rst           = (k == 1);
            bus_b.if_req  = (k == 0) || (k == 2);
            bus_b.if_addr = (k == 0) ? 32'h8 : 32'hC;
            @(negedge clk);
            check_eq("rstw_if_gnt", 32'(bus_b.if_gnt), 32'((k == 0) || (k == 2)));
            check_eq("rstw_if_rvalid", 32'(bus_b.if_rvalid), 32'(k == 5));
            if (k == 2) check_eq("rstw_state_idle", 32'(state_b), 32'(ARB_IDLE));
            if (k == 5) check_eq("rstw_if_rdata", bus_b.if_rdata, init_word(3));
            next_cycle();
        end
        idle_inputs();

        // Fresh reset, then randomized traffic on the latency-1 instance.
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        if_pend = 0; d_pend = 0; busy_until = 0; starve = 0;
        i_addr = 0; d_addr = 0; d_wdata = 0; d_be = 0; d_we = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (if_pend && $urandom_range(0, 15) == 0) if_pend = 0;
            if (d_pend && $urandom_range(0, 15) == 0) d_pend = 0;
            if (!if_pend && $urandom_range(0, 2) != 0) begin
                if_pend = 1; i_addr = rand_addr();
            end
            if (!d_pend && $urandom_range(0, 2) != 0) begin
                d_pend = 1; d_addr = rand_addr(); d_we = 1'($urandom_range(0, 1));
                d_be = 4'($urandom_range(0, 15)); d_wdata = $urandom;
            end
            bus_a.if_req = if_pend; bus_a.if_addr = i_addr;
            bus_a.d_req = d_pend; bus_a.d_addr = d_addr; bus_a.d_we = d_we;
            bus_a.d_be = d_be; bus_a.d_wdata = d_wdata;
            @(negedge clk);

            exp_iv = 0; exp_dv = 0; exp_id = 0; exp_dd = 0;
            if (due_q.size() > 0 && due_q[0] == cyc) begin
                if (tgt_q[0]) begin exp_dv = 1; exp_dd = exp_q[0]; end
                else          begin exp_iv = 1; exp_id = exp_q[0]; end
                void'(due_q.pop_front()); void'(tgt_q.pop_front()); void'(exp_q.pop_front());
            end
            check_eq("rnd_if_rvalid", 32'(bus_a.if_rvalid), 32'(exp_iv));
            check_eq("rnd_d_rvalid", 32'(bus_a.d_rvalid), 32'(exp_dv));
            check_eq("rnd_if_rdata", bus_a.if_rdata, exp_id);
            check_eq("rnd_d_rdata", bus_a.d_rdata, exp_dd);

            allowed = (cyc >= busy_until);
            exp_d = allowed && d_pend && !(if_pend && starve >= 4);
            exp_i = allowed && if_pend && !exp_d;
            check_eq("rnd_if_gnt", 32'(bus_a.if_gnt), 32'(exp_i));
            check_eq("rnd_d_gnt", 32'(bus_a.d_gnt), 32'(exp_d));
            check_eq("rnd_mem_en", 32'(bus_a.mem_en), 32'(exp_i || exp_d));
            if (exp_i || exp_d) begin
                g_addr = exp_d ? d_addr : i_addr;
                widx = int'(g_addr[9:2]);
                check_eq("rnd_mem_addr", 32'(bus_a.mem_addr), 32'(widx));
                check_eq("rnd_mem_we", 32'(bus_a.mem_we), 32'(exp_d && d_we));
                if (exp_d && d_we) begin
                    exp_q.push_back(32'h0);
                    for (int b = 0; b < 4; b++)
                        if (d_be[b]) ref_mem[widx][8*b +: 8] = d_wdata[8*b +: 8];
                end else begin
                    exp_q.push_back(ref_mem[widx]);
                end
                due_q.push_back(cyc + 1);
                tgt_q.push_back(exp_d);
                busy_until = cyc + 1;
            end
            if (allowed) begin
                if (exp_i) starve = 0;
                else if (if_pend) starve = (starve < 15) ? starve + 1 : 15;
            end
            next_cycle();
            if (exp_i) if_pend = 0;
            if (exp_d) d_pend = 0;
        end
        idle_inputs();
        next_cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
